// File: rtl/prio_grant_arbiter_if.sv
// Request/grant bundle between the requesting engines (master) and the arbiter (slave).
interface prio_grant_arbiter_if #(
  parameter int N   = 8,
  parameter int IDW = 3
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           forced_rel;

  modport master (output req, input gnt, gnt_id, gnt_valid, forced_rel);
  modport slave  (input req, output gnt, gnt_id, gnt_valid, forced_rel);
endinterface

// File: rtl/prio_grant_arbiter.sv
// Registered one-hot hold-until-release arbiter, highest index wins, optional MAX_HOLD revocation.
// Define ARB_ROUND_ROBIN_EN to rotate priority upward from the last winner instead.
module prio_grant_arbiter #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 0,
  parameter int CNTW     = 8
) (
  input logic                clk,
  input logic                rst,
  prio_grant_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNTW-1:0] MAX_HOLD_C = CNTW'(MAX_HOLD);
  localparam logic [N-1:0]    ONE_HOT_0  = {{(N-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            forced_rel_q, forced_rel_d;
  logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    skip_mask_q, skip_mask_d;
  logic [IDW-1:0]  rr_ptr_q;
  logic [N-1:0]    eff;
  logic [IDW-1:0]  win;
  logic            owner_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr_d;

  // Rotating search: scanning offsets downward lets the nearest index above rr_ptr win.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + 1 + k) % N;
      if (eff[idx[IDW-1:0]]) win = idx[IDW-1:0];
    end
  end
`else
  assign rr_ptr_q = IDW'(N - 1);

  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (eff[i]) win = i[IDW-1:0];
    end
  end
`endif

  assign eff       = bus.req & ~skip_mask_q;
  assign owner_req = |(bus.req & gnt_q);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    forced_rel_d = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    skip_mask_d  = skip_mask_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        skip_mask_d = '0;
        if (|eff) begin
          state_d    = GRANT;
          gnt_d      = ONE_HOT_0 << win;
          gnt_id_d   = win;
          hold_cnt_d = CNTW'(1);
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d   = win;
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
        end else if (MAX_HOLD != 0 && hold_cnt_q == MAX_HOLD_C) begin
          // Revoked owner sits out exactly one arbitration so others get a turn.
          state_d      = IDLE;
          gnt_d        = '0;
          gnt_id_d     = '0;
          hold_cnt_d   = '0;
          forced_rel_d = 1'b1;
          skip_mask_d  = gnt_q;
        end else if (hold_cnt_q != {CNTW{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      forced_rel_q <= 1'b0;
      hold_cnt_q   <= '0;
      skip_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      forced_rel_q <= forced_rel_d;
      hold_cnt_q   <= hold_cnt_d;
      skip_mask_q  <= skip_mask_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= IDW'(N - 1);
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign bus.gnt        = gnt_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.gnt_valid  = |gnt_q;
  assign bus.forced_rel = forced_rel_q;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// Directed bench: three arbiters (MAX_HOLD 0, 4, 2) sharing clock and reset.
module tb_prio_grant_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  prio_grant_arbiter_if #(.N(8), .IDW(3)) bus_a ();
  prio_grant_arbiter_if #(.N(8), .IDW(3)) bus_b ();
  prio_grant_arbiter_if #(.N(8), .IDW(3)) bus_c ();

  prio_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(0), .CNTW(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  prio_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(4), .CNTW(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  prio_grant_arbiter #(.N(8), .IDW(3), .MAX_HOLD(2), .CNTW(8)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus_a.req = '0;
    bus_b.req = '0;
    bus_c.req = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid, bus_a.forced_rel} !== 13'h0) begin
      errors++;
      $display("FAIL reset_a: gnt=%h id=%0d v=%b f=%b required all 0", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid, bus_a.forced_rel);
    end
    checks++;
    if ({bus_b.gnt, bus_b.gnt_id, bus_b.gnt_valid, bus_b.forced_rel} !== 13'h0) begin
      errors++;
      $display("FAIL reset_b: gnt=%h id=%0d v=%b f=%b required all 0", bus_b.gnt, bus_b.gnt_id, bus_b.gnt_valid, bus_b.forced_rel);
    end
    checks++;
    if ({bus_c.gnt, bus_c.gnt_id, bus_c.gnt_valid, bus_c.forced_rel} !== 13'h0) begin
      errors++;
      $display("FAIL reset_c: gnt=%h id=%0d v=%b f=%b required all 0", bus_c.gnt, bus_c.gnt_id, bus_c.gnt_valid, bus_c.forced_rel);
    end
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_idle;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({bus_a.gnt_valid, bus_a.gnt_id, bus_b.gnt_valid, bus_b.gnt_id} !== 8'h0) begin
        errors++;
        $display("FAIL idle cycle %0d: a v=%b id=%0d b v=%b id=%0d required 0", i, bus_a.gnt_valid, bus_a.gnt_id, bus_b.gnt_valid, bus_b.gnt_id);
      end
    end
    $display("idle: 20 cycles with req=0");
  endtask

`ifndef ARB_ROUND_ROBIN_EN
  task automatic test_fixed_priority;
    bus_a.req = 8'hA0;
    step();
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid} !== {8'h80, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL fixed_A0: gnt=%h id=%0d v=%b required 80/7/1", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid);
    end
    bus_a.req = 8'h20;
    step();
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid} !== 12'h0) begin
      errors++;
      $display("FAIL release_7: gnt=%h id=%0d v=%b required 00/0/0", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid);
    end
    step();
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid} !== {8'h20, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL grant_5: gnt=%h id=%0d v=%b required 20/5/1", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid);
    end
    // Higher requesters arrive; owner 5 keeps the grant with no time limit.
    bus_a.req = 8'hE0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({bus_a.gnt, bus_a.gnt_id, bus_a.forced_rel} !== {8'h20, 3'd5, 1'b0}) begin
        errors++;
        $display("FAIL no_preempt cycle %0d: gnt=%h id=%0d f=%b required 20/5/0", i, bus_a.gnt, bus_a.gnt_id, bus_a.forced_rel);
      end
    end
    bus_a.req = 8'h00;
    step();
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid} !== 12'h0) begin
      errors++;
      $display("FAIL release_5: gnt=%h id=%0d v=%b required 00/0/0", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid);
    end
    $display("fixed_priority: A0 -> 7, then 20 -> 5, no preemption");
  endtask

  task automatic test_forced_release;
    logic [7:0] exp_g  [11] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80};
    logic [2:0] exp_id [11] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
    logic       exp_f  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus_b.req = 8'h81;
    for (int i = 0; i < 11; i++) begin
      step();
      checks++;
      if ({bus_b.gnt, bus_b.gnt_id, bus_b.gnt_valid, bus_b.forced_rel} !== {exp_g[i], exp_id[i], |exp_g[i], exp_f[i]}) begin
        errors++;
        $display("FAIL forced_81 cycle %0d: gnt=%h id=%0d v=%b f=%b required %h/%0d/%b/%b", i,
                 bus_b.gnt, bus_b.gnt_id, bus_b.gnt_valid, bus_b.forced_rel, exp_g[i], exp_id[i], |exp_g[i], exp_f[i]);
      end
    end
    bus_b.req = 8'h00;
    step();
    checks++;
    if ({bus_b.gnt, bus_b.forced_rel} !== 9'h0) begin
      errors++;
      $display("FAIL forced_81_drop: gnt=%h f=%b required 00/0", bus_b.gnt, bus_b.forced_rel);
    end
    $display("forced_release: 81 alternates 7 and 0, 4 cycles each");
  endtask
`endif

  task automatic test_sole_requester;
    logic [7:0] exp_g [7] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10};
    logic       exp_f [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus_b.req = 8'h10;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if ({bus_b.gnt, bus_b.gnt_id, bus_b.forced_rel} !== {exp_g[i], (exp_g[i] != 0) ? 3'd4 : 3'd0, exp_f[i]}) begin
        errors++;
        $display("FAIL sole_10 cycle %0d: gnt=%h id=%0d f=%b required %h/f=%b", i, bus_b.gnt, bus_b.gnt_id, bus_b.forced_rel, exp_g[i], exp_f[i]);
      end
    end
    bus_b.req = 8'h00;
    step();
    $display("sole_requester: 10 revoked, skipped one cycle, re-granted");
  endtask

  task automatic test_coincident_release;
    bus_b.req = 8'h02;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus_b.gnt, bus_b.gnt_id} !== {8'h02, 3'd1}) begin
        errors++;
        $display("FAIL coinc_hold cycle %0d: gnt=%h id=%0d required 02/1", i, bus_b.gnt, bus_b.gnt_id);
      end
    end
    // Drop req on the very edge where hold_cnt reaches MAX_HOLD.
    bus_b.req = 8'h00;
    step();
    checks++;
    if ({bus_b.gnt, bus_b.gnt_valid, bus_b.forced_rel} !== 10'h0) begin
      errors++;
      $display("FAIL coinc_release: gnt=%h v=%b f=%b required 00/0/0", bus_b.gnt, bus_b.gnt_valid, bus_b.forced_rel);
    end
    $display("coincident_release: voluntary drop at expiry gives no forced_rel");
  endtask

  task automatic test_reset_mid_grant;
    bus_a.req = 8'h08;
    step();
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL mid_grant_pre: gnt=%h id=%0d v=%b required 08/3/1", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid);
    end
    #4;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid, bus_a.forced_rel} !== 13'h0) begin
      errors++;
      $display("FAIL async_reset: gnt=%h id=%0d v=%b f=%b required all 0", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid, bus_a.forced_rel);
    end
    #2;
    rst = 1'b0;
    step();
    checks++;
    if ({bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid, bus_a.forced_rel} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL regrant_after_reset: gnt=%h id=%0d v=%b f=%b required 08/3/1/0", bus_a.gnt, bus_a.gnt_id, bus_a.gnt_valid, bus_a.forced_rel);
    end
    bus_a.req = 8'h00;
    step();
    $display("reset_mid_grant: owner 3 dropped without a clock edge");
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin;
    logic [7:0] eg;
    logic [2:0] eid;
    bus_c.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      eid = 3'(g % 8);
      eg  = 8'd1 << eid;
      for (int h = 0; h < 2; h++) begin
        step();
        checks++;
        if ({bus_c.gnt, bus_c.gnt_id, bus_c.gnt_valid, bus_c.forced_rel} !== {eg, eid, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL rr grant %0d cycle %0d: gnt=%h id=%0d f=%b required %h/%0d/0", g, h, bus_c.gnt, bus_c.gnt_id, bus_c.forced_rel, eg, eid);
        end
      end
      if (g < 8) begin
        step();
        checks++;
        if ({bus_c.gnt, bus_c.gnt_valid, bus_c.forced_rel} !== {8'h00, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL rr gap %0d: gnt=%h v=%b f=%b required 00/0/1", g, bus_c.gnt, bus_c.gnt_valid, bus_c.forced_rel);
        end
      end
    end
    bus_c.req = 8'h00;
    step();
    $display("round_robin: ids 0..7,0 with 2-cycle grants");
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
`ifndef ARB_ROUND_ROBIN_EN
    test_fixed_priority();
    test_forced_release();
`else
    test_round_robin();
`endif
    test_sole_requester();
    test_coincident_release();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
